rr_arbiter_bin: RTL and testbench

Round-robin arbiter that picks one requester out of a REQ_N-bit request vector and presents the winner as a registered binary index. It sits directly upstream of the binary-to-one-hot decoder: Gnt_Idx_O drives the decoder's binary input, and the decoder's one-hot output becomes the per-requester grant lines. A valid/ready handshake holds each grant stable until the consumer accepts it. After acceptance, priority rotates to the requester after the winner.

---
 rtl/rr_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/rr_arbiter_bin.sv | 70 +++++++
 tb/tb_rr_arbiter_bin.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin binary-index arbiter.
package rr_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int unsigned REQ_N_DEF = 16;
  localparam int unsigned IDX_W_DEF = 4;

  // Priority pointer after an accepted grant; lock keeps priority on the winner.
  function automatic int unsigned next_ptr(input int unsigned idx,
                                           input logic        lock,
                                           input int unsigned n);
    return lock ? idx : ((idx + 1) % n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate, lowest-index-first search, rotate back.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned REQ_N = REQ_N_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic [REQ_N-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [2*REQ_N-1:0] dbl;
  logic [REQ_N-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Bit 0 of rot is requester ptr, so the search begins at the pointer.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[REQ_N-1:0];

  always_comb begin
    off = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (rot[REQ_N-1-i]) off = IDX_W'(REQ_N-1-i);
    end
  end

  // Power-of-two REQ_N makes the IDX_W overflow the wrap back to 0.
  assign winner  = ptr + off;
  assign any_req = |req;

endmodule

// File: rtl/rr_arbiter_bin.sv
// Round-robin arbiter with registered binary grant index and valid/ready hold.
// Optional feature: define RR_ARB_LOCK_EN to add Lock_I (repeat winner on accept).
module rr_arbiter_bin
  import rr_arb_pkg::*;
#(
  parameter int unsigned REQ_N = REQ_N_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             Clk_I,
  input  logic             Rst_I,
  input  logic [REQ_N-1:0] Req_I,
  input  logic             Gnt_Ready_I,
`ifdef RR_ARB_LOCK_EN
  input  logic             Lock_I,
`endif
  output logic             Gnt_Valid_O,
  output logic [IDX_W-1:0] Gnt_Idx_O
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             lock;

`ifdef RR_ARB_LOCK_EN
  assign lock = Lock_I;
`else
  assign lock = 1'b0;
`endif

  rr_pick #(
    .REQ_N (REQ_N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (Req_I),
    .ptr     (ptr),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  always_ff @(posedge Clk_I) begin
    if (Rst_I) begin
      state       <= ARB;
      ptr         <= '0;
      Gnt_Valid_O <= 1'b0;
      Gnt_Idx_O   <= '0;
    end else begin
      case (state)
        ARB: begin
          if (pick_any) begin
            Gnt_Idx_O   <= pick_idx;
            Gnt_Valid_O <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // Grant stays presented regardless of Req_I until accepted.
          if (Gnt_Ready_I) begin
            Gnt_Valid_O <= 1'b0;
            ptr         <= IDX_W'(next_ptr(32'(Gnt_Idx_O), lock, REQ_N));
            state       <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_bin.sv
// Directed self-checking bench for rr_arbiter_bin (lock test only with RR_ARB_LOCK_EN).
module tb_rr_arbiter_bin;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        ready;
  logic        lock;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;

  int unsigned n_cmp;
  int unsigned n_err;

  rr_arbiter_bin #(
    .REQ_N (16),
    .IDX_W (4)
  ) dut (
    .Clk_I       (clk),
    .Rst_I       (rst),
    .Req_I       (req),
    .Gnt_Ready_I (ready),
`ifdef RR_ARB_LOCK_EN
    .Lock_I      (lock),
`endif
    .Gnt_Valid_O (gnt_valid),
    .Gnt_Idx_O   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    ready = 1'b0;
    lock  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int unsigned c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_valid cycle %0d: got %b want 0", c, gnt_valid);
      end
      n_cmp++;
      if (gnt_idx !== 4'd0) begin
        n_err++;
        $display("FAIL reset_idx cycle %0d: got %0d want 0", c, gnt_idx);
      end
    end
  endtask

  task automatic test_rotation();
    logic       exp_v [8];
    logic [3:0] exp_i [8];
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_i = '{4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd4, 4'd0};
    do_reset();
    req   = 16'h0011;
    ready = 1'b1;
    for (int unsigned c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (gnt_valid !== exp_v[c]) begin
        n_err++;
        $display("FAIL rotation_valid cycle %0d: got %b want %b", c, gnt_valid, exp_v[c]);
      end
      if (exp_v[c]) begin
        n_cmp++;
        if (gnt_idx !== exp_i[c]) begin
          n_err++;
          $display("FAIL rotation_idx cycle %0d: got %0d want %0d", c, gnt_idx, exp_i[c]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req   = 16'h4000;
    ready = 1'b1;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd14) begin
      n_err++;
      $display("FAIL wrap_setup: got v=%b idx=%0d want v=1 idx=14", gnt_valid, gnt_idx);
    end
    tick();
    req = 16'h8001;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd15) begin
      n_err++;
      $display("FAIL wrap_first: got v=%b idx=%0d want v=1 idx=15", gnt_valid, gnt_idx);
    end
    tick();
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_next: got v=%b idx=%0d want v=1 idx=0", gnt_valid, gnt_idx);
    end
  endtask

  task automatic test_sticky();
    do_reset();
    req   = 16'h0008;
    ready = 1'b0;
    tick();
    req = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 4'd3) begin
        n_err++;
        $display("FAIL sticky_hold cycle %0d: got v=%b idx=%0d want v=1 idx=3", c, gnt_valid, gnt_idx);
      end
      tick();
    end
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd3) begin
      n_err++;
      $display("FAIL sticky_last: got v=%b idx=%0d want v=1 idx=3", gnt_valid, gnt_idx);
    end
    ready = 1'b1;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_accept: got v=%b want 0", gnt_valid);
    end
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_idle: got v=%b want 0", gnt_valid);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    // Move the pointer to 2 so a stale pointer would pick 2 instead of 1.
    req   = 16'h0002;
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd1) begin
      n_err++;
      $display("FAIL midhold_setup: got v=%b idx=%0d want v=1 idx=1", gnt_valid, gnt_idx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (gnt_valid !== 1'b0 || gnt_idx !== 4'd0) begin
      n_err++;
      $display("FAIL midhold_reset: got v=%b idx=%0d want v=0 idx=0", gnt_valid, gnt_idx);
    end
    req = 16'h0006;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd1) begin
      n_err++;
      $display("FAIL midhold_regrant: got v=%b idx=%0d want v=1 idx=1", gnt_valid, gnt_idx);
    end
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req   = 16'h0003;
    ready = 1'b1;
    lock  = 1'b1;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd0) begin
      n_err++;
      $display("FAIL lock_first: got v=%b idx=%0d want v=1 idx=0", gnt_valid, gnt_idx);
    end
    tick();
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd0) begin
      n_err++;
      $display("FAIL lock_repeat: got v=%b idx=%0d want v=1 idx=0", gnt_valid, gnt_idx);
    end
    lock = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd1) begin
      n_err++;
      $display("FAIL lock_release: got v=%b idx=%0d want v=1 idx=1", gnt_valid, gnt_idx);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = '0;
    ready = 1'b0;
    lock  = 1'b0;
    #2;
    test_reset();
    test_rotation();
    test_wrap();
    test_sticky();
    test_reset_mid_hold();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
